riscv_pipeline_top: RTL and testbench



---
 rtl/riscv_pipeline_top.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_riscv_pipeline_top.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipeline_top.sv
// Five-stage RV32I-subset pipeline: ADD SUB AND OR SLT ADDI LW SW BEQ.
// Define FORWARDING_EN for EX bypassing; otherwise ID interlocks on EX/MEM producers.

package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [7:0]  pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        use_imm;
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [7:0]  pc;
  } id_ex_t;

  typedef struct packed {
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] store;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;

endpackage

module riscv_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] register;

  // One architectural register, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      register <= '0;
    end else if (we_i) begin
      register <= d_i;
    end
  end

  assign q_o = register;

endmodule

module riscv_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs [32];

  for (genvar i = 0; i < 32; i++) begin : generate_registers
    logic we;
    // x0 exists as a cell but can never be written.
    assign we = we_i
             && (waddr_i == 5'(i))
             && (i != 0);
    riscv_reg register (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we_i  (we),
      .d_i   (wdata_i),
      .q_o   (regs[i])
    );
  end

  // Read ports with write-through of the value being written this cycle.
  always_comb begin
    rdata1_o = regs[raddr1_i];
    rdata2_o = regs[raddr2_i];
    if (raddr1_i == 5'd0) begin
      rdata1_o = '0;
    end else if (we_i && waddr_i == raddr1_i) begin
      rdata1_o = wdata_i;
    end
    if (raddr2_i == 5'd0) begin
      rdata2_o = '0;
    end else if (we_i && waddr_i == raddr2_i) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

module riscv_datapath
  import riscv_pkg::*;
(
  input logic clk_i,
  input logic rst_i
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [7:0]  pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic [31:0] if_instr;
  logic [31:0] dmem [64];

  function automatic logic [31:0] rom_word(
    input logic [5:0] a
  );
    case (a)
      6'd0:    rom_word = 32'h0020_0093;
      6'd1:    rom_word = 32'h0040_0113;
      6'd2:    rom_word = 32'h4011_01B3;
      6'd3:    rom_word = 32'h0000_8233;
      6'd4:    rom_word = 32'h0020_82B3;
      6'd5:    rom_word = 32'h0041_8333;
      default: rom_word = NOP;
    endcase
  endfunction

  assign if_instr = rom_word(pc_q[7:2]);

  // ---------------- ID ----------------
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b;
  logic        op_add, op_sub, op_and, op_or;
  logic        op_slt, op_addi, op_lw, op_sw;
  logic        op_beq, is_r;
  logic        use1, use2;
  logic [31:0] rf_rd1, rf_rd2;
  id_ex_t      dec;

  assign ins   = if_id_q.instr;
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25],
                  ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};

  assign is_r    = if_id_q.valid
                && opc == 7'b0110011;
  assign op_add  = is_r && f3 == 3'b000
                && f7 == 7'b0000000;
  assign op_sub  = is_r && f3 == 3'b000
                && f7 == 7'b0100000;
  assign op_and  = is_r && f3 == 3'b111
                && f7 == 7'b0000000;
  assign op_or   = is_r && f3 == 3'b110
                && f7 == 7'b0000000;
  assign op_slt  = is_r && f3 == 3'b010
                && f7 == 7'b0000000;
  assign op_addi = if_id_q.valid
                && opc == 7'b0010011
                && f3 == 3'b000;
  assign op_lw   = if_id_q.valid
                && opc == 7'b0000011
                && f3 == 3'b010;
  assign op_sw   = if_id_q.valid
                && opc == 7'b0100011
                && f3 == 3'b010;
  assign op_beq  = if_id_q.valid
                && opc == 7'b1100011
                && f3 == 3'b000;

  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;

  assign wb_we   = mem_wb_q.reg_we;
  assign wb_rd   = mem_wb_q.rd;
  assign wb_data = mem_wb_q.data;

  riscv_regfile regFile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (ins[19:15]),
    .raddr2_i (ins[24:20]),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  // Decode into an ID/EX bundle; unknown encodings stay a bubble.
  always_comb begin
    dec         = '0;
    use1        = 1'b0;
    use2        = 1'b0;
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.rd      = ins[11:7];
    dec.rs1_val = rf_rd1;
    dec.rs2_val = rf_rd2;
    dec.pc      = if_id_q.pc;
    unique case (1'b1)
      op_add, op_sub, op_and,
      op_or, op_slt: begin
        dec.reg_we = 1'b1;
        use1       = 1'b1;
        use2       = 1'b1;
        unique case (1'b1)
          op_sub:  dec.alu_op = ALU_SUB;
          op_and:  dec.alu_op = ALU_AND;
          op_or:   dec.alu_op = ALU_OR;
          op_slt:  dec.alu_op = ALU_SLT;
          default: dec.alu_op = ALU_ADD;
        endcase
      end
      op_addi: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        use1        = 1'b1;
      end
      op_lw: begin
        dec.reg_we  = 1'b1;
        dec.mem_re  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        use1        = 1'b1;
      end
      op_sw: begin
        dec.mem_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
        use1        = 1'b1;
        use2        = 1'b1;
      end
      op_beq: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_b;
        use1       = 1'b1;
        use2       = 1'b1;
      end
      default: ;
    endcase
    // Writes to x0 are dropped here so nothing downstream sees them.
    if (dec.rd == 5'd0) begin
      dec.reg_we = 1'b0;
    end
  end

  logic hit_ex;
  logic stall;

  assign hit_ex = id_ex_q.reg_we
               && ((use1 && dec.rs1 == id_ex_q.rd)
                || (use2 && dec.rs2 == id_ex_q.rd));

`ifdef FORWARDING_EN
  assign stall = hit_ex && id_ex_q.mem_re;
`else
  logic hit_mem;
  assign hit_mem = ex_mem_q.reg_we
                && ((use1 && dec.rs1 == ex_mem_q.rd)
                 || (use2 && dec.rs2 == ex_mem_q.rd));
  assign stall = hit_ex || hit_mem;
`endif

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;
  logic        br_taken;
  logic [7:0]  br_target;

  // Operand selection, newest producer first.
  always_comb begin
    fwd_a = id_ex_q.rs1_val;
    fwd_b = id_ex_q.rs2_val;
`ifdef FORWARDING_EN
    if (ex_mem_q.reg_we && !ex_mem_q.mem_re
        && ex_mem_q.rd != 5'd0
        && ex_mem_q.rd == id_ex_q.rs1) begin
      fwd_a = ex_mem_q.alu;
    end else if (mem_wb_q.reg_we
        && mem_wb_q.rd != 5'd0
        && mem_wb_q.rd == id_ex_q.rs1) begin
      fwd_a = mem_wb_q.data;
    end
    if (ex_mem_q.reg_we && !ex_mem_q.mem_re
        && ex_mem_q.rd != 5'd0
        && ex_mem_q.rd == id_ex_q.rs2) begin
      fwd_b = ex_mem_q.alu;
    end else if (mem_wb_q.reg_we
        && mem_wb_q.rd != 5'd0
        && mem_wb_q.rd == id_ex_q.rs2) begin
      fwd_b = mem_wb_q.data;
    end
`endif
  end

  assign alu_b = id_ex_q.use_imm
               ? id_ex_q.imm : fwd_b;

  // ALU; SLT is a signed compare.
  always_comb begin
    case (id_ex_q.alu_op)
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_SLT: alu_y = {31'd0,
                 $signed(fwd_a) < $signed(alu_b)};
      default: alu_y = fwd_a + alu_b;
    endcase
  end

  assign br_taken  = id_ex_q.branch
                  && (fwd_a == fwd_b);
  assign br_target = id_ex_q.pc
                   + id_ex_q.imm[7:0];

  // EX/MEM bundle.
  always_comb begin
    ex_mem_d        = '0;
    ex_mem_d.reg_we = id_ex_q.reg_we;
    ex_mem_d.mem_re = id_ex_q.mem_re;
    ex_mem_d.mem_we = id_ex_q.mem_we;
    ex_mem_d.rd     = id_ex_q.rd;
    ex_mem_d.alu    = alu_y;
    ex_mem_d.store  = fwd_b;
  end

  // ---------------- MEM ----------------
  logic [31:0] ld_data;

  assign ld_data = dmem[ex_mem_q.alu[7:2]];

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ex_mem_q.mem_we) begin
      dmem[ex_mem_q.alu[7:2]] <= ex_mem_q.store;
    end
  end

  // MEM/WB bundle.
  always_comb begin
    mem_wb_d        = '0;
    mem_wb_d.reg_we = ex_mem_q.reg_we;
    mem_wb_d.rd     = ex_mem_q.rd;
    mem_wb_d.data   = ex_mem_q.mem_re
                    ? ld_data : ex_mem_q.alu;
  end

  // ---------------- IF / control ----------------
  // Next PC and front-end registers; a taken branch beats a stall.
  always_comb begin
    pc_d           = pc_q + 8'd4;
    if_id_d.valid  = 1'b1;
    if_id_d.pc     = pc_q;
    if_id_d.instr  = if_instr;
    id_ex_d        = dec;
    if (br_taken) begin
      pc_d    = br_target;
      if_id_d = '0;
      id_ex_d = '0;
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  // Pipeline state; reset leaves bubbles everywhere.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule

module riscv_pipeline_top (
  input logic clk,
  input logic rst
);

  riscv_datapath datapath (
    .clk_i (clk),
    .rst_i (rst)
  );

endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Bench for riscv_pipeline_top: default ROM, mid-run reset and injected programs.
// Register writes are checked against cycle-stamped expectations from a queue.

module tb_riscv_pipeline_top;

`ifdef FORWARDING_EN
  localparam int X6_CYC  = 10;
  localparam int DEP_CYC = 6;
  localparam int LU_CYC  = 9;
  localparam int BR_ADD  = 9;
`else
  localparam int X6_CYC  = 13;
  localparam int DEP_CYC = 8;
  localparam int LU_CYC  = 12;
  localparam int BR_ADD  = 11;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          prog;
    int          cyc;
    int          rix;
    logic [31:0] val;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] xr [32];
  logic [31:0] prog [64];
  logic [31:0] cur_instr;
  vec_t        tbl [$];
  vec_t        exp_q [$];
  logic [31:0] dflt [32];

  always #5 clk = ~clk;

  riscv_pipeline_top dut (
    .clk (clk),
    .rst (rst)
  );

  for (genvar g = 0; g < 32; g++) begin : tap
    assign xr[g] = dut.datapath.regFile
      .generate_registers[g].register.register;
  end

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [2:0] f3,
    input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd),
            7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [2:0] f3, input int rd,
    input int rs1, input int imm);
    return {12'(imm), 5'(rs1), f3, 5'(rd),
            7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lw(
    input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd),
            7'b0000011};
  endfunction

  function automatic logic [31:0] enc_sw(
    input int rs2, input int rs1, input int imm);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010,
            m[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_beq(
    input int rs1, input int rs2, input int imm);
    logic [12:0] m;
    m = 13'(imm);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1),
            3'b000, m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(
    input int rd, input int rs1, input int imm);
    return enc_i(3'b000, rd, rs1, imm);
  endfunction

  task automatic check(input string name,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic add_vec(input int p, input int c,
    input int r, input logic [31:0] v);
    vec_t e;
    e.prog = p;
    e.cyc  = c;
    e.rix  = r;
    e.val  = v;
    tbl.push_back(e);
  endtask

  task automatic load_prog(input int p);
    for (int k = 0; k < 64; k++) prog[k] = NOP;
    case (p)
      1: begin
        prog[0] = addi(1, 0, 5);
        prog[1] = enc_r(7'h00, 3'b000, 2, 1, 1);
      end
      2: begin
        prog[0] = addi(1, 0, 7);
        prog[1] = enc_sw(1, 0, 0);
        prog[2] = enc_lw(3, 0, 0);
        prog[3] = enc_r(7'h00, 3'b000, 4, 3, 3);
      end
      3: begin
        prog[0] = enc_beq(0, 0, 8);
        prog[1] = addi(7, 0, 1);
        prog[2] = addi(9, 0, 3);
        prog[3] = enc_r(7'h00, 3'b000, 10, 9, 9);
      end
      4: begin
        prog[0] = addi(0, 0, 9);
        prog[1] = enc_r(7'h00, 3'b000, 8, 0, 0);
        prog[2] = enc_i(3'b100, 12, 0, 5);
        prog[3] = addi(10, 0, 1);
      end
      5: begin
        prog[0] = addi(1, 0, -3);
        prog[1] = addi(2, 0, 5);
        prog[2] = enc_r(7'h00, 3'b010, 3, 1, 2);
        prog[3] = enc_r(7'h00, 3'b010, 4, 2, 1);
        prog[4] = enc_r(7'h00, 3'b111, 5, 1, 2);
        prog[5] = enc_r(7'h00, 3'b110, 6, 1, 2);
        prog[6] = enc_r(7'h20, 3'b000, 7, 1, 2);
        prog[7] = enc_r(7'h00, 3'b000, 13, 1, 2);
        prog[8] = enc_beq(1, 2, 8);
        prog[9] = addi(15, 0, 1);
      end
      default: ;
    endcase
  endtask

  task automatic drive_instr(input bit use_rom);
    if (!use_rom) begin
      cur_instr = prog[dut.datapath.pc_q[7:2]];
      force dut.datapath.if_instr = cur_instr;
    end
  endtask

  task automatic apply_reset(input bit use_rom);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset pc", 32'(dut.datapath.pc_q), 32'd0);
    check("reset ifid valid",
          32'(dut.datapath.if_id_q.valid), 32'd0);
    check("reset idex we",
          32'(dut.datapath.id_ex_q.reg_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_instr(use_rom);
  endtask

  task automatic run_prog(input int p, input bit use_rom);
    int   last;
    vec_t v;
    last = 0;
    exp_q.delete();
    foreach (tbl[k]) begin
      if (tbl[k].prog == p) begin
        exp_q.push_back(tbl[k]);
        if (tbl[k].cyc > last) last = tbl[k].cyc;
      end
    end
    if (!use_rom) load_prog(p);
    apply_reset(use_rom);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      drive_instr(use_rom);
      while (exp_q.size() > 0 && exp_q[0].cyc <= c) begin
        v = exp_q.pop_front();
        check($sformatf("p%0d c%0d x%0d",
                        p, c, v.rix), xr[v.rix], v.val);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: no finish by 300000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 32; r++) dflt[r] = '0;
    dflt[1] = 32'd2;
    dflt[2] = 32'd4;
    dflt[3] = 32'd2;
    dflt[4] = 32'd2;
    dflt[5] = 32'd6;
    dflt[6] = 32'd4;

    add_vec(0, X6_CYC - 1, 6, 32'd0);
    add_vec(0, X6_CYC, 6, 32'd4);
    for (int r = 0; r < 32; r++) add_vec(0, 20, r, dflt[r]);

    add_vec(1, 5, 1, 32'd5);
    add_vec(1, DEP_CYC - 1, 2, 32'd0);
    add_vec(1, DEP_CYC, 2, 32'd10);
    add_vec(1, 20, 2, 32'd10);

    add_vec(2, LU_CYC - 1, 4, 32'd0);
    add_vec(2, LU_CYC, 4, 32'd14);
    add_vec(2, 20, 1, 32'd7);
    add_vec(2, 20, 3, 32'd7);
    add_vec(2, 20, 4, 32'd14);

    add_vec(3, 7, 9, 32'd0);
    add_vec(3, 8, 9, 32'd3);
    add_vec(3, BR_ADD - 1, 10, 32'd0);
    add_vec(3, BR_ADD, 10, 32'd6);
    add_vec(3, 20, 7, 32'd0);

    add_vec(4, 7, 10, 32'd0);
    add_vec(4, 8, 10, 32'd1);
    add_vec(4, 20, 0, 32'd0);
    add_vec(4, 20, 8, 32'd0);
    add_vec(4, 20, 12, 32'd0);

    add_vec(5, 25, 3, 32'd1);
    add_vec(5, 25, 4, 32'd0);
    add_vec(5, 25, 5, 32'd5);
    add_vec(5, 25, 6, 32'hFFFF_FFFD);
    add_vec(5, 25, 7, 32'hFFFF_FFF8);
    add_vec(5, 25, 13, 32'd2);
    add_vec(5, 25, 15, 32'd1);

    run_prog(0, 1'b1);

    // Reset in the middle of the default program.
    apply_reset(1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("midrun x1 before", xr[1], 32'd2);
    check("midrun x2 before", xr[2], 32'd4);
    rst = 1'b1;
    #1;
    check("midrun pc", 32'(dut.datapath.pc_q), 32'd0);
    check("midrun x1 cleared", xr[1], 32'd0);
    check("midrun x2 cleared", xr[2], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      check($sformatf("rerun x%0d", r), xr[r], dflt[r]);
    end

    for (int p = 1; p <= 5; p++) run_prog(p, 1'b0);
    check("dmem word0",
          dut.datapath.dmem[0], 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
